// File: rtl/doitgen_loader.sv
`default_nettype none
// ============================================================================
// Module      : doitgen_loader
// Description : Upstream feeder for the doitgen tensor-contraction stage.
//               Collects a serial element stream (X matrix first, then the
//               A tensor) under a valid/ready handshake, packs it into wide
//               A/X words, and captures the nr/nq/np loop bounds. One
//               validated frame is presented at a time and held until the
//               consumer accepts it. Malformed frames are dropped with a
//               one-cycle frame_err pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_nr/nq/np          loop bounds, sampled on a frame's first element
//   in_data/valid/last    element stream input, in_ready back-pressure
//   out_a, out_x          packed A / X (first element in the MSBs)
//   out_nr/nq/np          captured loop bounds
//   out_valid/out_ready   frame handshake to the compute stage
//   frame_err             one-cycle pulse per dropped frame
//   frame_cnt             delivered-frame counter (wraps)
// Configuration
//   DOITGEN_LDR_CKSUM_EN  when defined, each frame carries one trailing
//                         mod-2^ELEM_W sum of all data elements; in_last
//                         belongs on that checksum element.
// ============================================================================
module doitgen_loader #(
    parameter int ELEM_W  = 8,
    parameter int A_ELEMS = 8,
    parameter int X_ELEMS = 4,
    parameter int DIM_W   = 2,
    parameter int DIM_MAX = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIM_W-1:0]            cfg_nr,
    input  logic [DIM_W-1:0]            cfg_nq,
    input  logic [DIM_W-1:0]            cfg_np,
    input  logic [ELEM_W-1:0]           in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [A_ELEMS*ELEM_W-1:0]   out_a,
    output logic [X_ELEMS*ELEM_W-1:0]   out_x,
    output logic [DIM_W-1:0]            out_nr,
    output logic [DIM_W-1:0]            out_nq,
    output logic [DIM_W-1:0]            out_np,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        frame_err,
    output logic [15:0]                 frame_cnt
);

    localparam int c_DATA = X_ELEMS + A_ELEMS;
`ifdef DOITGEN_LDR_CKSUM_EN
    localparam int c_TOTAL = c_DATA + 1;
`else
    localparam int c_TOTAL = c_DATA;
`endif
    localparam int c_CNT_W = $clog2(c_TOTAL + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(c_TOTAL - 1);
    localparam logic [c_CNT_W-1:0] c_X_END    = c_CNT_W'(X_ELEMS);
    localparam logic [DIM_W-1:0]   c_DIM_MAX  = DIM_W'(DIM_MAX);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_LOAD    = 2'd1;
    localparam logic [1:0] c_ST_RESYNC  = 2'd2;
    localparam logic [1:0] c_ST_PRESENT = 2'd3;

    logic [1:0]                  r_state;
    logic [1:0]                  w_next_state;
    logic                        r_started;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [X_ELEMS*ELEM_W-1:0]   r_x_sh;
    logic [A_ELEMS*ELEM_W-1:0]   r_a_sh;
    logic [DIM_W-1:0]            r_nr, r_nq, r_np;
    logic [A_ELEMS*ELEM_W-1:0]   r_out_a;
    logic [X_ELEMS*ELEM_W-1:0]   r_out_x;
    logic [DIM_W-1:0]            r_out_nr, r_out_nq, r_out_np;
    logic                        r_err;
    logic [15:0]                 r_frame_cnt;

    logic                        w_in_fire;
    logic                        w_out_fire;
    logic                        w_final;
    logic                        w_bounds_ok;
    logic                        w_cksum_ok;
    logic                        w_is_data;
    logic                        w_drop;
    logic [X_ELEMS*ELEM_W-1:0]   w_x_shift;
    logic [A_ELEMS*ELEM_W-1:0]   w_a_shift;
    logic [A_ELEMS*ELEM_W-1:0]   w_a_final;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_final    = (r_cnt == c_LAST_IDX);
    assign w_x_shift  = {r_x_sh[X_ELEMS*ELEM_W-ELEM_W-1:0], in_data};
    assign w_a_shift  = {r_a_sh[A_ELEMS*ELEM_W-ELEM_W-1:0], in_data};

    assign w_bounds_ok = (r_nr != '0) && (r_nr <= c_DIM_MAX) &&
                         (r_nq != '0) && (r_nq <= c_DIM_MAX) &&
                         (r_np != '0) && (r_np <= c_DIM_MAX);

`ifdef DOITGEN_LDR_CKSUM_EN
    localparam logic [c_CNT_W-1:0] c_DATA_END = c_CNT_W'(c_DATA);
    logic [ELEM_W-1:0] r_sum;
    // The final element is the checksum, so A is already complete.
    assign w_is_data  = (r_cnt < c_DATA_END);
    assign w_cksum_ok = (in_data == r_sum);
    assign w_a_final  = r_a_sh;
`else
    // The final element is the last A element; fold it in while presenting.
    assign w_is_data  = 1'b1;
    assign w_cksum_ok = 1'b1;
    assign w_a_final  = w_a_shift;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // A one-element frame can never be well formed.
                if (in_valid && r_started)
                    w_next_state = in_last ? c_ST_IDLE : c_ST_LOAD;
            end
            c_ST_LOAD: begin
                if (in_valid) begin
                    if (w_final) begin
                        if (!in_last)
                            w_next_state = c_ST_RESYNC;
                        else if (w_bounds_ok && w_cksum_ok)
                            w_next_state = c_ST_PRESENT;
                        else
                            w_next_state = c_ST_IDLE;
                    end else if (in_last) begin
                        w_next_state = c_ST_IDLE;
                    end
                end
            end
            c_ST_RESYNC: begin
                if (in_valid && in_last)
                    w_next_state = c_ST_IDLE;
            end
            c_ST_PRESENT: begin
                if (out_ready)
                    w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Output / decode logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // Held low for the first cycle after reset release.
                in_ready = r_started;
                w_drop   = in_valid & r_started & in_last;
            end
            c_ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_final)
                        w_drop = ~(in_last & w_bounds_ok & w_cksum_ok);
                    else
                        w_drop = in_last;
                end
            end
            c_ST_RESYNC: begin
                in_ready = 1'b1;
            end
            c_ST_PRESENT: begin
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: working shift registers, frame capture and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started   <= 1'b0;
            r_cnt       <= '0;
            r_x_sh      <= '0;
            r_a_sh      <= '0;
            r_nr        <= '0;
            r_nq        <= '0;
            r_np        <= '0;
            r_out_a     <= '0;
            r_out_x     <= '0;
            r_out_nr    <= '0;
            r_out_nq    <= '0;
            r_out_np    <= '0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
`ifdef DOITGEN_LDR_CKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_started <= 1'b1;
            r_err     <= w_drop;
            if (w_out_fire)
                r_frame_cnt <= r_frame_cnt + 16'd1;

            if (w_in_fire && r_state == c_ST_IDLE) begin
                r_x_sh <= w_x_shift;
                r_nr   <= cfg_nr;
                r_nq   <= cfg_nq;
                r_np   <= cfg_np;
                r_cnt  <= c_CNT_W'(1);
`ifdef DOITGEN_LDR_CKSUM_EN
                r_sum  <= in_data;
`endif
            end else if (w_in_fire && r_state == c_ST_LOAD) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt < c_X_END)
                    r_x_sh <= w_x_shift;
                else if (w_is_data)
                    r_a_sh <= w_a_shift;
`ifdef DOITGEN_LDR_CKSUM_EN
                if (w_is_data)
                    r_sum <= r_sum + in_data;
`endif
                // Output registers change only when a new frame is presented.
                if (w_next_state == c_ST_PRESENT) begin
                    r_out_a  <= w_a_final;
                    r_out_x  <= r_x_sh;
                    r_out_nr <= r_nr;
                    r_out_nq <= r_nq;
                    r_out_np <= r_np;
                end
            end
        end
    end

    assign out_a     = r_out_a;
    assign out_x     = r_out_x;
    assign out_nr    = r_out_nr;
    assign out_nq    = r_out_nq;
    assign out_np    = r_out_np;
    assign frame_err = r_err;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_doitgen_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_doitgen_loader
// Description : Self-checking bench for doitgen_loader. Table of frame
//               vectors plus hand-written back-pressure and mid-frame reset
//               sequences; expected frames are queued on a scoreboard when
//               driven and compared when the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_doitgen_loader;

    localparam int NDATA = 12;
`ifdef DOITGEN_LDR_CKSUM_EN
    localparam int NTOT = NDATA + 1;
`else
    localparam int NTOT = NDATA;
`endif
    localparam int LP_NORMAL = -2;   // in_last on the proper final element
    localparam int LP_NONE   = -1;   // no in_last at all, then junk tail

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cfg_nr = '0, cfg_nq = '0, cfg_np = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic        in_ready;
    logic [63:0] out_a;
    logic [31:0] out_x;
    logic [1:0]  out_nr, out_nq, out_np;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        frame_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    doitgen_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_nr    (cfg_nr),
        .cfg_nq    (cfg_nq),
        .cfg_np    (cfg_np),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_x     (out_x),
        .out_nr    (out_nr),
        .out_nq    (out_nq),
        .out_np    (out_np),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [1:0] nr, nq, np;
        int         last_pos;
        logic [7:0] base;
        bit         exp_ok;
        int         exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] a;
        logic [31:0] x;
        logic [5:0]  dims;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   err_seen = 0;
    int   exp_fcnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic exp_t mk(input vec_t v);
        exp_t e;
        e.a = '0;
        e.x = '0;
        for (int i = 0; i < 4; i++)     e.x = {e.x[23:0], 8'(v.base + i)};
        for (int i = 4; i < NDATA; i++) e.a = {e.a[55:0], 8'(v.base + i)};
        e.dims = {v.nr, v.nq, v.np};
        return e;
    endfunction

    // Drive one element and hold it until a handshake completes.
    task automatic send_elem(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 1'b0, 1'b1);
            in_valid = 1'b0; in_last = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0] sum;
        sum = '0;
        cfg_nr = v.nr; cfg_nq = v.nq; cfg_np = v.np;
        if (v.exp_ok) sb.push_back(mk(v));
        if (v.last_pos == LP_NORMAL) begin
            for (int i = 0; i < NDATA; i++) begin
                sum = sum + 8'(v.base + i);
`ifdef DOITGEN_LDR_CKSUM_EN
                send_elem(8'(v.base + i), 1'b0);
`else
                send_elem(8'(v.base + i), i == NDATA - 1);
`endif
            end
`ifdef DOITGEN_LDR_CKSUM_EN
            send_elem(sum, 1'b1);
`endif
        end else if (v.last_pos == LP_NONE) begin
            for (int i = 0; i < NTOT; i++) send_elem(8'(v.base + i), 1'b0);
            send_elem(8'hEE, 1'b0);
            send_elem(8'hEF, 1'b0);
            send_elem(8'hF0, 1'b1);
        end else begin
            for (int i = 0; i <= v.last_pos; i++)
                send_elem(8'(v.base + i), i == v.last_pos);
        end
    endtask

    // Scoreboard monitor: frames are compared at the handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (frame_err) err_seen++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("out_a", out_a, e.a);
                    chk("out_x", {32'h0, out_x}, {32'h0, e.x});
                    chk("bounds", {out_nr, out_nq, out_np}, e.dims);
                    exp_fcnt++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e0;
        vec_t v;

        vecs[0] = '{2'd2, 2'd2, 2'd2, LP_NORMAL, 8'h01, 1'b1, 0};
        vecs[1] = '{2'd1, 2'd2, 2'd1, LP_NORMAL, 8'h20, 1'b1, 0};
        vecs[2] = '{2'd2, 2'd2, 2'd0, LP_NORMAL, 8'h30, 1'b0, 1};
        vecs[3] = '{2'd2, 2'd2, 2'd3, LP_NORMAL, 8'h30, 1'b0, 1};
        vecs[4] = '{2'd0, 2'd1, 2'd1, LP_NORMAL, 8'h38, 1'b0, 1};
        vecs[5] = '{2'd2, 2'd2, 2'd2, 6,         8'h60, 1'b0, 1};
        vecs[6] = '{2'd2, 2'd2, 2'd2, LP_NONE,   8'h70, 1'b0, 1};
        vecs[7] = '{2'd2, 2'd1, 2'd2, LP_NORMAL, 8'h80, 1'b1, 0};

        // Reset state
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_out_a", out_a, 64'd0);
        chk("rst_out_x", out_x, 32'd0);
        chk("rst_bounds", {out_nr, out_nq, out_np}, 6'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_before_first_clk", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("in_ready_after_first_clk", in_ready, 1'b1);

        // Table-driven frames
        for (int k = 0; k < 8; k++) begin
            e0 = err_seen;
            send_frame(vecs[k]);
            repeat (4) @(posedge clk);
            #1;
            chk("err_pulses", err_seen - e0, vecs[k].exp_err);
            chk("frame_cnt", frame_cnt, exp_fcnt);
            chk("sb_drained", sb.size(), 0);
            chk("valid_idle", out_valid, 1'b0);
            if (k == 0) begin
                chk("held_out_x", out_x, 32'h01020304);
                chk("held_out_a", out_a, 64'h05060708090A0B0C);
            end
        end

        // Back-pressure: frame held for 5 cycles, no input accepted meanwhile
        e0 = err_seen;
        out_ready = 1'b0;
        send_frame(vecs[0]);
        chk("valid_latency", out_valid, 1'b1);
        in_data = 8'h55; in_last = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_out_x", out_x, 32'h01020304);
            chk("hold_out_a", out_a, 64'h05060708090A0B0C);
            chk("hold_err", frame_err, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        v = '{2'd2, 2'd2, 2'd2, LP_NORMAL, 8'h55, 1'b1, 0};
        send_frame(v);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_err_pulses", err_seen - e0, 0);
        chk("bp_frame_cnt", frame_cnt, exp_fcnt);
        chk("bp_sb_drained", sb.size(), 0);

        // Reset in the middle of a frame
        e0 = err_seen;
        cfg_nr = 2'd2; cfg_nq = 2'd2; cfg_np = 2'd2;
        for (int i = 0; i < 6; i++) send_elem(8'(8'h90 + i), 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_frame_cnt", frame_cnt, 16'd0);
        exp_fcnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{2'd2, 2'd2, 2'd2, LP_NORMAL, 8'h40, 1'b1, 0};
        send_frame(v);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_err_pulses", err_seen - e0, 0);
        chk("midrst_frame_cnt_after", frame_cnt, 16'd1);
        chk("midrst_sb_drained", sb.size(), 0);

`ifdef DOITGEN_LDR_CKSUM_EN
        // Explicit checksum values: 0x4E is the sum of 0x01..0x0C
        e0 = err_seen;
        cfg_nr = 2'd2; cfg_nq = 2'd2; cfg_np = 2'd2;
        for (int i = 0; i < NDATA; i++) send_elem(8'(i + 1), 1'b0);
        send_elem(8'h4F, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("cksum_bad_err", err_seen - e0, 1);
        chk("cksum_bad_cnt", frame_cnt, exp_fcnt);
        v = '{2'd2, 2'd2, 2'd2, LP_NORMAL, 8'h01, 1'b1, 0};
        sb.push_back(mk(v));
        for (int i = 0; i < NDATA; i++) send_elem(8'(i + 1), 1'b0);
        send_elem(8'h4E, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("cksum_good_err", err_seen - e0, 1);
        chk("cksum_good_cnt", frame_cnt, exp_fcnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/doitgen_loader.md
Name: doitgen_loader

Overview:
- Upstream feeder for the doitgen tensor-contraction stage.
- Collects a serial 8-bit element stream (X matrix, then A tensor) under a valid/ready handshake and packs it into the wide A/X words the compute stage consumes.
- Also captures the nr/nq/np loop bounds.
- Presents one complete, validated frame at a time and holds it until the consumer accepts it.

Parameters:
- ELEM_W, 8, bit width of one tensor element.
- A_ELEMS, 8, elements in the A tensor (2x2x2).
- X_ELEMS, 4, elements in the X matrix (2x2).
- DIM_W, 2, width of each loop-bound field.
- DIM_MAX, 2, largest legal loop bound.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cfg_nr  in  DIM_W  r loop bound; sampled on first element of a frame
- cfg_nq  in  DIM_W  q loop bound; sampled with cfg_nr
- cfg_np  in  DIM_W  p/s loop bound; sampled with cfg_nr
- in_data  in  ELEM_W  stream element
- in_valid  in  1  element valid
- in_last  in  1  marks final element of a frame
- in_ready  out  1  loader can accept an element
- out_a  out  A_ELEMS*ELEM_W  packed A; first A element in MSBs ([0][0][0] to [1][1][1])
- out_x  out  X_ELEMS*ELEM_W  packed X; first X element in MSBs ([0][0] to [1][1])
- out_nr, out_nq, out_np  out  DIM_W each  captured bounds
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts frame
- frame_err  out  1  one-cycle pulse on a dropped frame
- frame_cnt  out  16  count of frames delivered; wraps 0xFFFF to 0

Behaviour:
- Transfer occurs on any cycle where valid and ready are both high (input side and output side alike).
- Reset (async assert, sync release) values:
  - in_ready = 0, out_valid = 0, frame_err = 0, frame_cnt = 0
  - out_a, out_x, out_* bounds = 0
  - FSM in IDLE; element counter = 0
- in_ready goes to 1 on the first clock after reset release.
- Reset mid-frame discards all partial data; no err pulse.
- Frame format: X_ELEMS X elements, then A_ELEMS A elements (12 total by default). in_last is required on the final element.
- FSM states:
  - IDLE: in_ready = 1. First accepted element is stored as X element 0, cfg_* are latched, and counter becomes 1; go to LOAD.
  - LOAD: in_ready = 1. Each accepted element is shifted into the X register for counter < X_ELEMS, otherwise into the A register; counter increments.
    - Final element (counter = 11) with in_last = 1 and bounds legal: go to PRESENT.
    - Final element with in_last = 1 and any bound equal to 0 or greater than DIM_MAX: drop the frame, pulse frame_err, go to IDLE.
    - in_last = 1 on any earlier element: drop the frame, pulse frame_err, go to IDLE. The offending element is consumed.
    - Final element with in_last = 0: drop the frame, pulse frame_err, go to RESYNC.
  - RESYNC: in_ready = 1. Discard elements until one is accepted with in_last = 1 (that element is also discarded); go to IDLE. No further err pulses.
  - PRESENT: in_ready = 0, out_valid = 1. out_a, out_x and out_* bounds stay stable while out_valid = 1 and out_ready = 0.
    - On output transfer: out_valid drops next cycle, frame_cnt increments, go to IDLE.
- Latency: out_valid rises on the clock edge that accepts the final element, so it is visible the cycle after that element's handshake.
- out_ready high with out_valid low has no effect.
- Outputs keep the last delivered frame's values after acceptance, until the next frame is presented.
- Single-buffered: the next frame's first element is accepted no earlier than the cycle after the output transfer.
- frame_err is a single-cycle pulse per dropped frame and never coincides with out_valid rising.

Optional Feature:
- Macro: DOITGEN_LDR_CKSUM_EN
- With macro defined:
  - Each frame carries one extra trailing element: the mod-2^ELEM_W sum of all data elements. in_last belongs on this element, not on the last data element.
  - Mismatch: drop the frame, pulse frame_err, go to IDLE.
  - in_last on the last data element counts as an early in_last.
- Without macro: no checksum element; the frame is exactly X_ELEMS + A_ELEMS elements.

Test Plan:
- Reset, then stream 0x01..0x0C with in_last on 0x0C, cfg = 2/2/2, out_ready = 1 -> out_x = 0x01020304, out_a = 0x05060708090A0B0C, bounds 2/2/2, out_valid high for 1 cycle, frame_cnt = 1, frame_err = 0.
- Same frame with out_ready held 0 for 5 cycles -> out_valid and outputs stable for all 5 cycles, in_ready = 0, next input element not accepted until after the output transfer.
- in_last on the 7th element, then a valid 12-element frame -> one frame_err pulse, first frame dropped, second frame delivered intact, frame_cnt = 1.
- 12 elements with no in_last, then 3 junk elements with in_last on the 3rd, then a valid frame -> frame_err once, junk discarded, valid frame delivered.
- cfg_np = 0 or 3 with a well-formed frame -> frame_err pulse, out_valid never asserted.
- Assert rst_n low after 6 elements, release, send a full frame -> only the new frame is delivered, no err pulse. With DOITGEN_LDR_CKSUM_EN: a checksum byte of 0x4E on 0x01..0x0C is accepted, 0x4F pulses frame_err.
